// File: rtl/rob_pkg.sv
// Shared types and default widths for the multi-commit reorder buffer.
package rob_pkg;
    localparam int ROB_DEPTH    = 16;
    localparam int ROB_WB_PORTS = 3;
    localparam int ROB_COMMIT_W = 2;
    localparam int ROB_XLEN     = 32;

    typedef enum logic [1:0] {
        K_ALU    = 2'd0,
        K_BRANCH = 2'd1,
        K_STORE  = 2'd2,
        K_LOAD   = 2'd3
    } rob_kind_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } st_state_e;

    function automatic logic writes_reg(rob_kind_e k);
        return (k == K_ALU) || (k == K_LOAD);
    endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// Decides which head entries retire this cycle and which side effects they raise.
module rob_commit_sel
    import rob_pkg::*;
#(
    parameter int COMMIT_W = ROB_COMMIT_W
) (
    input  logic      rdy,
    input  st_state_e st_state,
    input  logic      st_ack,
    input  logic      h0_busy,
    input  logic      h0_ready,
    input  logic      h0_addr_valid,
    input  rob_kind_e h0_kind,
    input  logic      h1_busy,
    input  logic      h1_ready,
    input  rob_kind_e h1_kind,
    output logic      retire0,
    output logic      retire1,
    output logic      commit0,
    output logic      commit1,
    output logic      branch0,
    output logic      store_go,
    output logic      store_done
);
    logic h0_ok;

    always_comb begin
        retire0    = 1'b0;
        retire1    = 1'b0;
        commit0    = 1'b0;
        commit1    = 1'b0;
        branch0    = 1'b0;
        store_go   = 1'b0;
        store_done = 1'b0;
        h0_ok      = rdy && h0_busy && h0_ready;
        if (st_state == S_WAIT) begin
            // the in-flight store is the head; only its ack can retire anything
            store_done = rdy && st_ack;
            retire0    = store_done;
        end else if (h0_ok) begin
            if (h0_kind == K_STORE) begin
                store_go = h0_addr_valid;
            end else begin
                retire0 = 1'b1;
                commit0 = writes_reg(h0_kind);
                branch0 = (h0_kind == K_BRANCH);
                retire1 = (COMMIT_W > 1) && commit0 && h1_busy && h1_ready && writes_reg(h1_kind);
                commit1 = retire1;
            end
        end
    end
endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with up to two in-order retirements per cycle, a store port and branch flush.
// state  | meaning
// S_IDLE | no store in flight; head retires through the normal slots
// S_WAIT | store request held with latched addr/data until st_ack_in; retirement stalled
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter  int DEPTH    = ROB_DEPTH,
    parameter  int WB_PORTS = ROB_WB_PORTS,
    parameter  int COMMIT_W = ROB_COMMIT_W,
    parameter  int XLEN     = ROB_XLEN,
    localparam int TW       = $clog2(DEPTH)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                alloc_valid_in,
    output logic                alloc_ready_out,
    input  rob_kind_e           alloc_kind_in,
    input  logic [4:0]          alloc_dest_in,
    input  logic [XLEN-1:0]     alloc_pc_in,
    input  logic                alloc_pred_taken_in,
    output logic [TW-1:0]       alloc_tag_out,
    input  logic [WB_PORTS-1:0] wb_valid_in,
    input  logic [TW-1:0]       wb_tag_in    [WB_PORTS],
    input  logic [XLEN-1:0]     wb_value_in  [WB_PORTS],
    input  logic [WB_PORTS-1:0] wb_taken_in,
    input  logic [XLEN-1:0]     wb_target_in [WB_PORTS],
    input  logic                addr_valid_in,
    input  logic [TW-1:0]       addr_tag_in,
    input  logic [XLEN-1:0]     addr_in,
    input  logic [TW-1:0]       qry_tag_in   [2],
    output logic [1:0]          qry_ready_out,
    output logic [XLEN-1:0]     qry_value_out [2],
    output logic [COMMIT_W-1:0] cm_valid_out,
    output logic [4:0]          cm_dest_out  [COMMIT_W],
    output logic [XLEN-1:0]     cm_value_out [COMMIT_W],
    output logic [TW-1:0]       cm_tag_out   [COMMIT_W],
    output logic                st_req_out,
    output logic [XLEN-1:0]     st_addr_out,
    output logic [XLEN-1:0]     st_data_out,
    input  logic                st_ack_in,
    output logic                bp_valid_out,
    output logic                bp_correct_out,
    output logic [XLEN-1:0]     bp_pc_out,
    output logic                flush_out,
    output logic [XLEN-1:0]     flush_pc_out,
    output logic [TW:0]         count_out
);
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] taken_q;
    logic [DEPTH-1:0] addr_v_q;
    rob_kind_e        kind_q   [DEPTH];
    logic [4:0]       dest_q   [DEPTH];
    logic [XLEN-1:0]  pc_q     [DEPTH];
    logic [XLEN-1:0]  value_q  [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  addr_q   [DEPTH];

    logic [TW-1:0]    head_q;
    logic [TW-1:0]    tail_q;
    logic [TW-1:0]    head1;
    logic [TW:0]      count_q;
    st_state_e        st_state_q;
    st_state_e        st_state_d;
    logic [XLEN-1:0]  st_addr_q;
    logic [XLEN-1:0]  st_data_q;

    logic             retire0;
    logic             retire1;
    logic             commit0;
    logic             commit1;
    logic             branch0;
    logic             store_go;
    logic             store_done;
    logic             full;
    logic             alloc_fire;
    logic             mispredict;
    logic [1:0]       n_ret;
    logic [1:0]       commit_v;

    assign head1       = head_q + TW'(1);
    assign full        = (count_q == (TW+1)'(DEPTH));
    assign mispredict  = branch0 && (pred_q[head_q] != taken_q[head_q]);
    assign alloc_ready_out = rdy_in && !full && !flush_out;
    assign alloc_fire  = alloc_valid_in && alloc_ready_out;
    assign n_ret       = {1'b0, retire0} + {1'b0, retire1};
    assign commit_v    = {commit1, commit0};

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W)
    ) u_sel (
        .rdy           (rdy_in),
        .st_state      (st_state_q),
        .st_ack        (st_ack_in),
        .h0_busy       (busy_q[head_q]),
        .h0_ready      (ready_q[head_q]),
        .h0_addr_valid (addr_v_q[head_q]),
        .h0_kind       (kind_q[head_q]),
        .h1_busy       (busy_q[head1]),
        .h1_ready      (ready_q[head1]),
        .h1_kind       (kind_q[head1]),
        .retire0       (retire0),
        .retire1       (retire1),
        .commit0       (commit0),
        .commit1       (commit1),
        .branch0       (branch0),
        .store_go      (store_go),
        .store_done    (store_done)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_out) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_q + TW'(n_ret);
                tail_q  <= tail_q + TW'(alloc_fire);
                count_q <= count_q + (TW+1)'(alloc_fire) - (TW+1)'(n_ret);
            end
        end
    end

    // later ports are applied last so the highest-numbered hit wins; retire clears busy after writeback
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q   <= '0;
            ready_q  <= '0;
            pred_q   <= '0;
            taken_q  <= '0;
            addr_v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kind_q[i]   <= K_ALU;
                dest_q[i]   <= '0;
                pc_q[i]     <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
                addr_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (flush_out) begin
                busy_q <= '0;
            end else begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid_in[p] && busy_q[wb_tag_in[p]]) begin
                        value_q[wb_tag_in[p]]  <= wb_value_in[p];
                        ready_q[wb_tag_in[p]]  <= 1'b1;
                        taken_q[wb_tag_in[p]]  <= wb_taken_in[p];
                        target_q[wb_tag_in[p]] <= wb_target_in[p];
                    end
                end
                if (addr_valid_in && busy_q[addr_tag_in]) begin
                    addr_q[addr_tag_in]   <= addr_in;
                    addr_v_q[addr_tag_in] <= 1'b1;
                end
                if (retire0) busy_q[head_q] <= 1'b0;
                if (retire1) busy_q[head1]  <= 1'b0;
                if (alloc_fire) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= 1'b0;
                    addr_v_q[tail_q] <= 1'b0;
                    kind_q[tail_q]   <= alloc_kind_in;
                    dest_q[tail_q]   <= alloc_dest_in;
                    pc_q[tail_q]     <= alloc_pc_in;
                    pred_q[tail_q]   <= alloc_pred_taken_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) st_state_q <= S_IDLE;
        else           st_state_q <= st_state_d;
    end

    always_comb begin
        st_state_d = st_state_q;
        case (st_state_q)
            S_IDLE:  if (store_go)   st_state_d = S_WAIT;
            S_WAIT:  if (store_done) st_state_d = S_IDLE;
            default: st_state_d = S_IDLE;
        endcase
    end

    // address and data are captured so a late duplicate writeback cannot disturb the request
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            st_addr_q <= '0;
            st_data_q <= '0;
        end else if (store_go) begin
            st_addr_q <= addr_q[head_q];
            st_data_q <= value_q[head_q];
        end
    end

    assign st_req_out    = rdy_in && (st_state_q == S_WAIT);
    assign st_addr_out   = st_addr_q;
    assign st_data_out   = st_data_q;
    assign count_out     = count_q;
    assign alloc_tag_out = tail_q;

    assign bp_valid_out   = branch0;
    assign bp_correct_out = branch0 && !mispredict;
    assign bp_pc_out      = branch0 ? pc_q[head_q] : '0;
    assign flush_out      = mispredict;
    assign flush_pc_out   = mispredict ? (taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + XLEN'(4)) : '0;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            cm_valid_out[k] = commit_v[k];
            cm_tag_out[k]   = '0;
            cm_dest_out[k]  = '0;
            cm_value_out[k] = '0;
            if (commit_v[k]) begin
                cm_tag_out[k]   = head_q + TW'(k);
                cm_dest_out[k]  = dest_q[head_q + TW'(k)];
                cm_value_out[k] = value_q[head_q + TW'(k)];
            end
        end
    end

    always_comb begin
        for (int q = 0; q < 2; q++) begin
            qry_ready_out[q] = busy_q[qry_tag_in[q]] && ready_q[qry_tag_in[q]];
            qry_value_out[q] = value_q[qry_tag_in[q]];
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rdy_in && wb_valid_in[p] && (wb_tag_in[p] == qry_tag_in[q]) && busy_q[qry_tag_in[q]]) begin
                    qry_ready_out[q] = 1'b1;
                    qry_value_out[q] = wb_value_in[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference.
module tb_rob_multi_commit;
    import rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int WB    = 3;
    localparam int CW    = 2;
    localparam int XLEN  = 32;
    localparam int TW    = 4;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic              alloc_valid_in;
    logic              alloc_ready_out;
    rob_kind_e         alloc_kind_in;
    logic [4:0]        alloc_dest_in;
    logic [XLEN-1:0]   alloc_pc_in;
    logic              alloc_pred_taken_in;
    logic [TW-1:0]     alloc_tag_out;
    logic [WB-1:0]     wb_valid_in;
    logic [TW-1:0]     wb_tag_in    [WB];
    logic [XLEN-1:0]   wb_value_in  [WB];
    logic [WB-1:0]     wb_taken_in;
    logic [XLEN-1:0]   wb_target_in [WB];
    logic              addr_valid_in;
    logic [TW-1:0]     addr_tag_in;
    logic [XLEN-1:0]   addr_in;
    logic [TW-1:0]     qry_tag_in   [2];
    logic [1:0]        qry_ready_out;
    logic [XLEN-1:0]   qry_value_out [2];
    logic [CW-1:0]     cm_valid_out;
    logic [4:0]        cm_dest_out  [CW];
    logic [XLEN-1:0]   cm_value_out [CW];
    logic [TW-1:0]     cm_tag_out   [CW];
    logic              st_req_out;
    logic [XLEN-1:0]   st_addr_out;
    logic [XLEN-1:0]   st_data_out;
    logic              st_ack_in;
    logic              bp_valid_out;
    logic              bp_correct_out;
    logic [XLEN-1:0]   bp_pc_out;
    logic              flush_out;
    logic [XLEN-1:0]   flush_pc_out;
    logic [TW:0]       count_out;

    always #5 clk_in = ~clk_in;

    rob_multi_commit #(
        .DEPTH (DEPTH), .WB_PORTS (WB), .COMMIT_W (CW), .XLEN (XLEN)
    ) dut (
        .clk_in (clk_in), .rst_n_in (rst_n_in), .rdy_in (rdy_in),
        .alloc_valid_in (alloc_valid_in), .alloc_ready_out (alloc_ready_out),
        .alloc_kind_in (alloc_kind_in), .alloc_dest_in (alloc_dest_in),
        .alloc_pc_in (alloc_pc_in), .alloc_pred_taken_in (alloc_pred_taken_in),
        .alloc_tag_out (alloc_tag_out),
        .wb_valid_in (wb_valid_in), .wb_tag_in (wb_tag_in), .wb_value_in (wb_value_in),
        .wb_taken_in (wb_taken_in), .wb_target_in (wb_target_in),
        .addr_valid_in (addr_valid_in), .addr_tag_in (addr_tag_in), .addr_in (addr_in),
        .qry_tag_in (qry_tag_in), .qry_ready_out (qry_ready_out), .qry_value_out (qry_value_out),
        .cm_valid_out (cm_valid_out), .cm_dest_out (cm_dest_out),
        .cm_value_out (cm_value_out), .cm_tag_out (cm_tag_out),
        .st_req_out (st_req_out), .st_addr_out (st_addr_out), .st_data_out (st_data_out),
        .st_ack_in (st_ack_in),
        .bp_valid_out (bp_valid_out), .bp_correct_out (bp_correct_out), .bp_pc_out (bp_pc_out),
        .flush_out (flush_out), .flush_pc_out (flush_pc_out), .count_out (count_out)
    );

    // reference: the buffer is a queue of in-flight entries, oldest first
    typedef struct {
        rob_kind_e   kind;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        pred;
        logic        done;
        logic [31:0] val;
        logic        taken;
        logic [31:0] tgt;
        logic        av;
        logic [31:0] addr;
    } ment_t;

    ment_t       q[$];
    int          m_head;
    bit          m_wait;
    logic [31:0] m_st_addr, m_st_data;
    int          checks = 0;
    int          errors = 0;

    int          e_nret;
    bit          e_c0, e_c1, e_bp, e_ok, e_flush, e_start, e_done, e_aready, e_streq;
    logic [31:0] e_fpc, e_bppc;
    bit          e_qr [2];
    logic [31:0] e_qv [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input int t);
        return (t - m_head + DEPTH) % DEPTH;
    endfunction

    function automatic bit is_reg(input rob_kind_e k);
        return (k == K_ALU) || (k == K_LOAD);
    endfunction

    task automatic model_reset();
        q.delete();
        m_head = 0;
        m_wait = 0;
        m_st_addr = '0;
        m_st_data = '0;
    endtask

    task automatic model_eval();
        int pos;
        e_nret = 0; e_c0 = 0; e_c1 = 0; e_bp = 0; e_ok = 0; e_flush = 0;
        e_start = 0; e_done = 0; e_fpc = '0; e_bppc = '0;
        if (rdy_in) begin
            if (m_wait) begin
                if (st_ack_in) begin e_done = 1; e_nret = 1; end
            end else if (q.size() > 0 && q[0].done) begin
                if (q[0].kind == K_STORE) begin
                    e_start = q[0].av;
                end else if (is_reg(q[0].kind)) begin
                    e_nret = 1; e_c0 = 1;
                    if (CW == 2 && q.size() > 1 && q[1].done && is_reg(q[1].kind)) begin
                        e_c1 = 1; e_nret = 2;
                    end
                end else begin
                    e_nret = 1; e_bp = 1;
                    e_ok = (q[0].pred == q[0].taken);
                    e_bppc = q[0].pc;
                    e_flush = !e_ok;
                    e_fpc = q[0].taken ? q[0].tgt : q[0].pc + 32'd4;
                end
            end
        end
        e_streq  = rdy_in && m_wait;
        e_aready = rdy_in && (q.size() < DEPTH) && !e_flush;
        for (int k = 0; k < 2; k++) begin
            pos = pos_of(int'(qry_tag_in[k]));
            e_qr[k] = 0;
            e_qv[k] = '0;
            if (pos < q.size()) begin
                e_qr[k] = q[pos].done;
                e_qv[k] = q[pos].val;
                if (rdy_in)
                    for (int p = 0; p < WB; p++)
                        if (wb_valid_in[p] && wb_tag_in[p] == qry_tag_in[k]) begin
                            e_qr[k] = 1;
                            e_qv[k] = wb_value_in[p];
                        end
            end
        end
    endtask

    task automatic compare_all();
        chk("alloc_ready", alloc_ready_out, e_aready);
        chk("alloc_tag", alloc_tag_out, (m_head + q.size()) % DEPTH);
        chk("count", count_out, q.size());
        chk("cm_valid", cm_valid_out, {e_c1, e_c0});
        if (e_c0) begin
            chk("cm_tag0", cm_tag_out[0], m_head);
            chk("cm_dest0", cm_dest_out[0], q[0].dest);
            chk("cm_value0", cm_value_out[0], q[0].val);
        end
        if (e_c1) begin
            chk("cm_tag1", cm_tag_out[1], (m_head + 1) % DEPTH);
            chk("cm_dest1", cm_dest_out[1], q[1].dest);
            chk("cm_value1", cm_value_out[1], q[1].val);
        end
        chk("bp_valid", bp_valid_out, e_bp);
        if (e_bp) begin
            chk("bp_correct", bp_correct_out, e_ok);
            chk("bp_pc", bp_pc_out, e_bppc);
        end
        chk("flush", flush_out, e_flush);
        if (e_flush) chk("flush_pc", flush_pc_out, e_fpc);
        chk("st_req", st_req_out, e_streq);
        if (e_streq) begin
            chk("st_addr", st_addr_out, m_st_addr);
            chk("st_data", st_data_out, m_st_data);
        end
        for (int k = 0; k < 2; k++) begin
            chk("qry_ready", qry_ready_out[k], e_qr[k]);
            if (e_qr[k]) chk("qry_value", qry_value_out[k], e_qv[k]);
        end
    endtask

    task automatic model_update();
        int    pos;
        ment_t e;
        if (!rdy_in) return;
        if (e_flush) begin
            q.delete();
            m_head = 0;
            return;
        end
        if (e_start) begin
            m_wait = 1;
            m_st_addr = q[0].addr;
            m_st_data = q[0].val;
        end
        if (e_done) m_wait = 0;
        for (int p = 0; p < WB; p++)
            if (wb_valid_in[p]) begin
                pos = pos_of(int'(wb_tag_in[p]));
                if (pos < q.size()) begin
                    q[pos].done  = 1;
                    q[pos].val   = wb_value_in[p];
                    q[pos].taken = wb_taken_in[p];
                    q[pos].tgt   = wb_target_in[p];
                end
            end
        if (addr_valid_in) begin
            pos = pos_of(int'(addr_tag_in));
            if (pos < q.size()) begin
                q[pos].av = 1;
                q[pos].addr = addr_in;
            end
        end
        repeat (e_nret) void'(q.pop_front());
        m_head = (m_head + e_nret) % DEPTH;
        if (alloc_valid_in && e_aready) begin
            e.kind = alloc_kind_in; e.dest = alloc_dest_in; e.pc = alloc_pc_in;
            e.pred = alloc_pred_taken_in; e.done = 0; e.val = '0; e.taken = 0;
            e.tgt = '0; e.av = 0; e.addr = '0;
            q.push_back(e);
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk_in);
        model_update();
        @(negedge clk_in);
    endtask

    task automatic clear_inputs();
        alloc_valid_in = 0;
        wb_valid_in = '0;
        addr_valid_in = 0;
        st_ack_in = 0;
    endtask

    task automatic alloc_set(input rob_kind_e k, input int dest, input logic [31:0] pc, input logic pred);
        alloc_valid_in = 1;
        alloc_kind_in = k;
        alloc_dest_in = 5'(dest);
        alloc_pc_in = pc;
        alloc_pred_taken_in = pred;
    endtask

    task automatic wb_set(input int p, input int tag, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        wb_valid_in[p] = 1;
        wb_tag_in[p] = TW'(tag);
        wb_value_in[p] = v;
        wb_taken_in[p] = tk;
        wb_target_in[p] = tg;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (count_out != 0 && n < budget) begin
            settle();
            advance();
            n++;
        end
        chk(name, count_out, 0);
    endtask

    function automatic logic [TW-1:0] pick_tag();
        if (q.size() > 0 && $urandom_range(0, 9) < 8)
            return TW'((m_head + $urandom_range(0, q.size() - 1)) % DEPTH);
        return TW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic rand_inputs();
        int r;
        rdy_in = ($urandom_range(0, 9) != 0);
        alloc_valid_in = ($urandom_range(0, 9) < 6);
        r = $urandom_range(0, 7);
        alloc_kind_in = (r < 3) ? K_ALU : (r < 5) ? K_LOAD : (r < 7) ? K_STORE : K_BRANCH;
        alloc_dest_in = 5'($urandom_range(0, 31));
        alloc_pc_in = 32'($urandom_range(0, 65535)) << 2;
        alloc_pred_taken_in = 1'($urandom_range(0, 1));
        for (int p = 0; p < WB; p++) begin
            wb_valid_in[p] = ($urandom_range(0, 9) < 4);
            wb_tag_in[p] = pick_tag();
            wb_value_in[p] = $urandom;
            wb_taken_in[p] = 1'($urandom_range(0, 1));
            wb_target_in[p] = $urandom & 32'hFFFF_FFFC;
        end
        addr_valid_in = ($urandom_range(0, 9) < 4);
        addr_tag_in = pick_tag();
        addr_in = $urandom;
        st_ack_in = ($urandom_range(0, 2) == 0);
        qry_tag_in[0] = pick_tag();
        qry_tag_in[1] = pick_tag();
    endtask

    initial begin
        rst_n_in = 0;
        rdy_in = 0;
        clear_inputs();
        alloc_set(K_ALU, 0, '0, 0);
        alloc_valid_in = 0;
        for (int p = 0; p < WB; p++) wb_set(p, 0, '0, 0, '0);
        wb_valid_in = '0;
        addr_tag_in = '0;
        addr_in = '0;
        qry_tag_in[0] = '0;
        qry_tag_in[1] = '0;
        model_reset();

        @(negedge clk_in);
        #1;
        chk("rst_count", count_out, 0);
        chk("rst_alloc_tag", alloc_tag_out, 0);
        chk("rst_st_req", st_req_out, 0);
        chk("rst_cm_valid", cm_valid_out, 0);
        chk("rst_flush", flush_out, 0);
        chk("rst_bp_valid", bp_valid_out, 0);
        @(negedge clk_in);
        rst_n_in = 1;
        rdy_in = 1;

        // fill all 16 entries with ALU ops
        for (int i = 0; i < 16; i++) begin
            alloc_set(K_ALU, i, 32'h100 + 32'(i * 4), 0);
            settle();
            advance();
        end
        settle();
        chk("full_ready", alloc_ready_out, 0);
        chk("full_count", count_out, 16);
        advance();
        wb_set(0, 0, 32'h11, 0, '0);
        wb_set(1, 1, 32'h22, 0, '0);
        settle();
        chk("no_17th", count_out, 16);
        advance();
        wb_valid_in = '0;
        settle();
        chk("dual_cm_valid", cm_valid_out, 2'b11);
        chk("dual_dest0", cm_dest_out[0], 0);
        chk("dual_val0", cm_value_out[0], 32'h11);
        chk("dual_dest1", cm_dest_out[1], 1);
        chk("dual_val1", cm_value_out[1], 32'h22);
        chk("full_retire_refuse", alloc_ready_out, 0);
        advance();
        alloc_valid_in = 0;
        settle();
        chk("after_dual_count", count_out, 14);
        advance();
        for (int t = 2; t < 16; t += 3) begin
            wb_valid_in = '0;
            for (int p = 0; p < WB; p++)
                if (t + p < 16) wb_set(p, t + p, 32'h1000 + 32'(t + p), 0, '0);
            settle();
            advance();
        end
        wb_valid_in = '0;
        wait_empty("drain1", 40);

        // same-cycle writeback forwarding, highest port wins
        for (int i = 0; i < 6; i++) begin
            alloc_set(K_LOAD, 20 + i, 32'h300, 0);
            settle();
            advance();
        end
        alloc_valid_in = 0;
        wb_set(0, 5, 32'h1, 0, '0);
        wb_set(2, 5, 32'h2, 0, '0);
        qry_tag_in[0] = 4'd5;
        qry_tag_in[1] = 4'd3;
        settle();
        chk("fwd_value", qry_value_out[0], 32'h2);
        chk("fwd_ready", qry_ready_out[0], 1);
        chk("unwritten_ready", qry_ready_out[1], 0);
        advance();
        wb_valid_in = '0;
        for (int t = 0; t < 5; t += 3) begin
            wb_valid_in = '0;
            for (int p = 0; p < WB; p++)
                if (t + p < 5) wb_set(p, t + p, 32'h50 + 32'(t + p), 0, '0);
            settle();
            advance();
        end
        wb_valid_in = '0;
        wait_empty("drain2", 20);

        // mispredicted branch at tag 6 with a younger ALU behind it
        alloc_set(K_BRANCH, 0, 32'h200, 0);
        settle();
        advance();
        alloc_set(K_ALU, 7, 32'h204, 0);
        settle();
        advance();
        alloc_valid_in = 0;
        wb_set(0, 6, 32'h0, 1, 32'h240);
        wb_set(1, 7, 32'h5, 0, '0);
        settle();
        advance();
        wb_valid_in = '0;
        alloc_set(K_ALU, 9, 32'h208, 0);
        settle();
        chk("br_bp_valid", bp_valid_out, 1);
        chk("br_correct", bp_correct_out, 0);
        chk("br_pc", bp_pc_out, 32'h200);
        chk("br_flush", flush_out, 1);
        chk("br_flush_pc", flush_pc_out, 32'h240);
        chk("br_alloc_drop", alloc_ready_out, 0);
        advance();
        alloc_valid_in = 0;
        settle();
        chk("br_count_after", count_out, 0);
        chk("br_tail_after", alloc_tag_out, 0);
        advance();

        // store with ack arriving on the fourth request cycle
        alloc_set(K_STORE, 0, 32'h400, 0);
        settle();
        advance();
        alloc_valid_in = 0;
        wb_set(0, 0, 32'hAB, 0, '0);
        addr_valid_in = 1;
        addr_tag_in = 4'd0;
        addr_in = 32'h1000;
        settle();
        advance();
        wb_valid_in = '0;
        addr_valid_in = 0;
        settle();
        chk("st_start_noreq", st_req_out, 0);
        advance();
        for (int i = 0; i < 4; i++) begin
            st_ack_in = (i == 3);
            settle();
            chk("st_req_held", st_req_out, 1);
            chk("st_addr_held", st_addr_out, 32'h1000);
            chk("st_data_held", st_data_out, 32'hAB);
            chk("st_count_held", count_out, 1);
            advance();
        end
        st_ack_in = 0;
        settle();
        chk("st_retired", count_out, 0);
        chk("st_req_dropped", st_req_out, 0);
        advance();

        // reset while a store is waiting
        alloc_set(K_STORE, 0, 32'h500, 0);
        settle();
        advance();
        alloc_valid_in = 0;
        wb_set(0, 1, 32'h5, 0, '0);
        addr_valid_in = 1;
        addr_tag_in = 4'd1;
        addr_in = 32'h2000;
        settle();
        advance();
        wb_valid_in = '0;
        addr_valid_in = 0;
        settle();
        advance();
        settle();
        chk("pre_rst_st_req", st_req_out, 1);
        #2;
        rst_n_in = 0;
        #1;
        chk("mid_rst_st_req", st_req_out, 0);
        chk("mid_rst_count", count_out, 0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1;

        repeat (3000) begin
            rand_inputs();
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rob_multi_commit.md
ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

Interface
REQ-001 The parameter DEPTH SHALL default to 16; it is the entry count, a power of two from 4 to 64, and TW = log2(DEPTH).
REQ-002 The parameter WB_PORTS SHALL default to 3; it is the number of writeback ports, 1..4.
REQ-003 The parameter COMMIT_W SHALL default to 2; it is the maximum number of retirements per cycle, 1 or 2.
REQ-004 The parameter XLEN SHALL default to 32; it is the data and address width.
REQ-005 clk_in  in  1  sole clock, rising edge.
REQ-006 rst_n_in  in  1  reset; asynchronous assert, active-low.
REQ-007 rdy_in  in  1  global enable; when low, all state holds and pulse outputs are 0.
REQ-008 alloc_valid_in/alloc_ready_out  in/out  1/1  dispatch handshake.
REQ-009 alloc_kind_in  in  2  entry kind: ALU, BRANCH, STORE or LOAD.
REQ-010 alloc_dest_in, alloc_pc_in, alloc_pred_taken_in  in  5/XLEN/1  destination register, PC, predicted direction.
REQ-011 alloc_tag_out  out  TW  tag of the tail entry.
REQ-012 wb_valid_in, wb_tag_in, wb_value_in, wb_taken_in, wb_target_in  in  WB_PORTS x (1/TW/XLEN/1/XLEN)  writeback.
REQ-013 addr_valid_in, addr_tag_in, addr_in  in  1/TW/XLEN  store address.
REQ-014 qry_tag_in[2]  in  2xTW; qry_ready_out[2], qry_value_out[2]  out  2x1/2xXLEN  operand lookup, combinational.
REQ-015 cm_valid_out, cm_dest_out, cm_value_out, cm_tag_out  out  COMMIT_W x (1/5/XLEN/TW)  register commit.
REQ-016 st_req_out, st_addr_out, st_data_out  out  1/XLEN/XLEN; st_ack_in  in  1  store port.
REQ-017 bp_valid_out, bp_correct_out, bp_pc_out  out  1/1/XLEN  branch resolution report.
REQ-018 flush_out, flush_pc_out  out  1/XLEN  misprediction redirect.
REQ-019 count_out  out  TW+1  occupancy.

Function
REQ-020 Head and tail SHALL each be a TW-bit pointer that wraps modulo DEPTH; a separate counter SHALL track occupancy, full when count == DEPTH and empty when count == 0.
REQ-021 alloc_ready_out SHALL equal rdy_in & !full & !flush_out; an accepted allocation SHALL write the tail entry with busy=1 and ready=0 in the same cycle and advance tail.
REQ-022 A writeback SHALL set value, ready and actual taken/target of a busy entry one cycle later; a writeback to a non-busy tag SHALL be ignored; when several ports hit the same tag, the highest-numbered port SHALL win.
REQ-023 qry_* SHALL return the stored value/ready; when the queried tag is written back in the same cycle, they SHALL forward the writeback value with ready=1.
REQ-024 Slot 0 SHALL retire the head when it is ready; for ALU and LOAD entries it SHALL pulse cm_valid_out[0].
REQ-025 Slot 1 SHALL retire head+1 only if slot 0 retired an ALU or LOAD entry and head+1 is a ready ALU or LOAD entry; BRANCH and STORE entries SHALL always retire alone.
REQ-026 A BRANCH at the head SHALL pulse bp_valid_out with bp_pc_out = pc and bp_correct_out = (pred == actual).
REQ-027 On misprediction, the same edge SHALL pulse flush_out with flush_pc_out = target if taken, else pc+4; the next edge SHALL clear every busy bit, set head = tail = 0 and count = 0, and drop any allocation in that cycle.
REQ-028 The store FSM SHALL have states S_IDLE and S_WAIT.
- S_IDLE -> S_WAIT when the head is a STORE with data ready and address valid.
- In S_WAIT, st_req_out SHALL be held at 1 with constant address and data until st_ack_in.
- On ack, the entry SHALL retire and the FSM SHALL return to S_IDLE.
- Nothing SHALL retire while the FSM is in S_WAIT.
REQ-029 Simultaneous allocation and retirement SHALL update count by (allocs - retires); allocation when full with retirement in the same cycle SHALL still be refused.

Reset
REQ-030 On assertion of rst_n_in, all outputs, pointers, count and busy bits SHALL be 0, the FSM SHALL be in S_IDLE, and st_req_out SHALL drop immediately, even mid-store.

Structure
REQ-031 The package rob_pkg SHALL hold the kind enum, the store-FSM state enum and the default widths.
REQ-032 The retire-eligibility and slot-selection logic SHALL be in one sub-module, rob_commit_sel.

Verification
REQ-033 Fill 16 ALU allocs with no writebacks -> alloc_ready_out=0 and count_out=16; a 17th request is not accepted.
REQ-034 Write back tags 0 and 1 with 0x11 and 0x22 in the same cycle -> the next cycle shows cm_valid_out=2'b11 with dest/values in order.
REQ-035 STORE at head with addr 0x1000 and data 0xAB, ack delayed 3 cycles -> st_req_out is held 4 cycles, then the entry retires.
REQ-036 BRANCH pc=0x200, predicted not-taken, actual taken to 0x240 -> flush_out=1 with flush_pc_out=0x240, bp_correct_out=0, and count_out=0 the next cycle.
REQ-037 Ports 0 and 2 write tag 5 with 0x1 and 0x2 -> qry returns 0x2 in the same cycle.
REQ-038 Reset during S_WAIT -> st_req_out=0 immediately and count_out=0.
